spi_slave_ctrl: RTL and testbench

//  SPI slave front-end feeding the single-port RAM. Deserialises MOSI frames into
//  a 10-bit {op[1:0],payload[7:0]} word with a one-cycle rx_valid strobe.
//  On read-data frames, captures the RAM's tx_data and serialises it onto MISO.

---
 rtl/spi_slave_ctrl.sv | 131 +++++++++++++
 tb/tb_spi_slave_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end: MOSI frames -> {op,payload} word with 1-cycle rx_valid; read-data frames stream RAM tx_data out on MISO.
// rx_valid lands the cycle after the last word bit; no backpressure -- SS_n high aborts any frame and returns to IDLE.
module spi_slave_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MOSI,
  input  logic              SS_n,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int WORD_W = DATA_W + 2;
  localparam int CNT_W  = $clog2(WORD_W);
  localparam int TXC_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] shreg;
  logic              word_done;
  logic              rd_addr_seen;
  logic              tx_wait;
  logic              tx_shift;
  logic [DATA_W-1:0] tx_sh;
  logic [TXC_W-1:0]  tx_left;
  logic              shifting;
  logic              last_bit;

  assign shifting = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
  assign last_bit = shifting && !word_done && (bit_cnt == CNT_W'(WORD_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (SS_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)             state_nxt = WRITE;
          else if (rd_addr_seen) state_nxt = READ_DATA;
          else                   state_nxt = READ_ADD;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      MISO         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      bit_cnt      <= '0;
      shreg        <= '0;
      word_done    <= 1'b0;
      rd_addr_seen <= 1'b0;
      tx_wait      <= 1'b0;
      tx_shift     <= 1'b0;
      tx_sh        <= '0;
      tx_left      <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n || !shifting) begin
        // Abort or between frames: drop partial word and any read-out in flight.
        bit_cnt   <= '0;
        shreg     <= '0;
        word_done <= 1'b0;
        tx_wait   <= 1'b0;
        tx_shift  <= 1'b0;
        tx_sh     <= '0;
        tx_left   <= '0;
        MISO      <= 1'b0;
      end else begin
        if (!word_done) begin
          shreg   <= {shreg[WORD_W-2:0], MOSI};
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (last_bit) begin
            rx_data   <= {shreg[WORD_W-2:0], MOSI};
            rx_valid  <= 1'b1;
            word_done <= 1'b1;
            bit_cnt   <= '0;
            if (state == READ_ADD)  rd_addr_seen <= 1'b1;
            if (state == READ_DATA) tx_wait      <= 1'b1;
          end
        end

        // MISO is registered, so the MSB appears the cycle after tx_valid.
        if (tx_wait && tx_valid) begin
          tx_wait  <= 1'b0;
          tx_shift <= 1'b1;
          MISO     <= tx_data[DATA_W-1];
          tx_sh    <= tx_data << 1;
          tx_left  <= TXC_W'(DATA_W - 1);
        end else if (tx_shift) begin
          if (tx_left == '0) begin
            MISO         <= 1'b0;
            tx_shift     <= 1'b0;
            rd_addr_seen <= 1'b0;
          end else begin
            MISO    <= tx_sh[DATA_W-1];
            tx_sh   <= tx_sh << 1;
            tx_left <= tx_left - TXC_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Scoreboard bench for spi_slave_ctrl: randomized SPI frames against a frame-level model.
module tb_spi_slave_ctrl;

  logic       clk;
  logic       rst;
  logic       MOSI;
  logic       SS_n;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  // Driver marks tx_valid pulses the model says fall inside the wait window.
  logic       tx_expect;
  logic       finish_req;
  logic       final_done;
  logic       m_seen;

  logic [9:0] exp_rx[$];
  logic       miso_q[$];
  logic [9:0] hold_word;
  int         n_pass;
  int         n_tot;

  spi_slave_ctrl #(.DATA_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .MOSI    (MOSI),
    .SS_n    (SS_n),
    .MISO    (MISO),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_valid(tx_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents rx_valid or MISO data.
  initial begin
    logic exp_bit;
    logic [9:0] w;
    n_pass = 0;
    n_tot = 0;
    hold_word = '0;
    final_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_miso", {31'd0, MISO}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_data", {22'd0, rx_data}, 32'd0);
        miso_q.delete();
        exp_rx.delete();
        hold_word = '0;
      end else begin
        if (tx_valid && tx_expect) begin
          for (int i = 7; i >= 0; i--) miso_q.push_back(tx_data[i]);
        end
        exp_bit = (miso_q.size() > 0) ? miso_q.pop_front() : 1'b0;
        chk("miso", {31'd0, MISO}, {31'd0, exp_bit});
        if (rx_valid) begin
          if (exp_rx.size() == 0) begin
            chk("rx_valid_unexpected", {31'd0, rx_valid}, 32'd0);
          end else begin
            w = exp_rx.pop_front();
            chk("rx_data", {22'd0, rx_data}, {22'd0, w});
            hold_word = w;
          end
        end else begin
          chk("rx_hold", {22'd0, rx_data}, {22'd0, hold_word});
        end
      end
      if (finish_req && !final_done) begin
        chk("rx_missing", exp_rx.size(), 32'd0);
        chk("miso_missing", miso_q.size(), 32'd0);
        final_done = 1'b1;
      end
    end
  end

  task automatic cyc(input logic ss, input logic mosi, input logic txv,
                     input logic [7:0] txd, input logic texp, input logic r);
    @(negedge clk);
    #1;
    SS_n = ss;
    MOSI = mosi;
    tx_valid = txv;
    tx_data = txd;
    tx_expect = texp;
    rst = r;
  endtask

  // One cycle with stray tx_valid traffic that the slave must ignore.
  task automatic noise(input logic ss, input logic mosi);
    cyc(ss, mosi, ($urandom_range(0, 3) == 0), 8'($urandom), 1'b0, 1'b0);
  endtask

  // abort_at: SS_n rises in place of that word bit (-1 = none).
  // rst_at: reset asserted that many cycles after the tx_valid pulse (-1 = none).
  task automatic frame(input logic cmd, input logic [9:0] word, input int extras,
                       input int abort_at, input int lat, input int rst_at, input int txd);
    logic rd_data;
    logic [7:0] d;
    rd_data = cmd && m_seen;
    noise(1'b0, 1'($urandom));
    noise(1'b0, cmd);
    for (int i = 0; i < 10; i++) begin
      if (i == abort_at) begin
        noise(1'b1, 1'($urandom));
        noise(1'b1, 1'($urandom));
        return;
      end
      noise(1'b0, word[9-i]);
    end
    exp_rx.push_back(word);
    if (cmd && !m_seen) m_seen = 1'b1;
    if (rd_data) begin
      for (int i = 0; i < lat; i++) cyc(1'b0, 1'($urandom), 1'b0, 8'($urandom), 1'b0, 1'b0);
      d = (txd < 0) ? 8'($urandom) : 8'(txd);
      cyc(1'b0, 1'($urandom), 1'b1, d, 1'b1, 1'b0);
      for (int i = 0; i < 9 + extras; i++) begin
        if (i == rst_at) begin
          cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
          m_seen = 1'b0;
          noise(1'b1, 1'b0);
          return;
        end
        noise(1'b0, 1'($urandom));
      end
      m_seen = 1'b0;
    end else begin
      for (int i = 0; i < extras; i++) noise(1'b0, 1'($urandom));
    end
    noise(1'b1, 1'($urandom));
    if ($urandom_range(0, 1) == 1) noise(1'b1, 1'($urandom));
  endtask

  initial begin
    int ab;
    int ra;
    rst = 1'b1;
    SS_n = 1'b1;
    MOSI = 1'b0;
    tx_valid = 1'b0;
    tx_data = '0;
    tx_expect = 1'b0;
    finish_req = 1'b0;
    m_seen = 1'b0;
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    frame(1'b0, 10'h005, 0, -1, 1, -1, -1);
    frame(1'b0, 10'h1A5, 5, -1, 1, -1, -1);
    frame(1'b1, 10'h203, 2, -1, 1, -1, -1);
    frame(1'b1, 10'h300, 2, -1, 1, -1, 8'hA5);
    frame(1'b0, 10'h2C7, 0, 5, 1, -1, -1);
    frame(1'b0, 10'h0F0, 1, -1, 1, -1, -1);
    frame(1'b1, 10'h111, 0, -1, 1, -1, -1);
    frame(1'b1, 10'h322, 0, -1, 2, 3, -1);
    frame(1'b1, 10'h155, 3, -1, 1, -1, -1);
    frame(1'b1, 10'h366, 1, -1, 4, -1, -1);
    frame(1'b1, 10'h0AA, 1, -1, 1, -1, -1);
    frame(1'b1, 10'h3C3, 1, 9, 1, -1, -1);
    frame(1'b1, 10'h3C4, 0, -1, 3, -1, -1);

    for (int k = 0; k < 80; k++) begin
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : -1;
      ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
      frame(1'($urandom), 10'($urandom), int'($urandom_range(0, 3)), ab,
            int'($urandom_range(1, 5)), ra, -1);
    end

    repeat (3) noise(1'b1, 1'b0);
    finish_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
